aes_core_arbiter: RTL and testbench

Shares one AES core between two requesters: requester 0 is encrypt and requester 1 is decrypt.
- Accepts one block at a time through valid/ready request channels, using round-robin grant.
- Issues a one-cycle start and a mode select to the core, then waits for the core's done pulse.
- Returns the result, source id and error flag on a single buffered response channel.
- Sits between the host-side DMA/register front end and the encryption/decryption round FSMs plus datapath.

---
 rtl/aes_arb_pkg.sv | 14 +
 rtl/aes_rr_arb2.sv | 11 +
 rtl/aes_core_arbiter.sv | 114 +++++++++++
 tb/tb_aes_core_arbiter.sv | 536 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// Shared types for the AES core arbiter: FSM state encoding and core mode values.
package aes_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, ptr breaks ties.
module aes_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | ~ptr);
    assign gnt[1] = req[1] & (~req[0] |  ptr);

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core between an encrypt (0) and a decrypt (1) requester, one job at a time,
// with a timeout on the core's done pulse and a single buffered response channel.
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter int unsigned DATA_W         = 128,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic              core_start,
    output logic              core_mode,
    output logic [DATA_W-1:0] core_din,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_src,
    output logic              rsp_err,
    output logic              busy,
    output logic [7:0]        err_count
);

    arb_state_e        state_q;
    logic              rr_ptr_q;
    logic              src_q;
    logic [DATA_W-1:0] din_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        gnt;

    aes_rr_arb2 u_rr_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    // Grants are only offered while idle, so a new job never overlaps a pending response.
    assign req_ready = (state_q == ARB_IDLE) ? gnt : 2'b00;
    assign core_mode = src_q;
    assign core_din  = din_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= 1'b0;
            src_q      <= MODE_ENC;
            din_q      <= '0;
            cnt_q      <= '0;
            core_start <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_src    <= 1'b0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            core_start <= 1'b0;
            unique case (state_q)
                ARB_IDLE: begin
                    if (|gnt) begin
                        din_q      <= gnt[1] ? req_data1 : req_data0;
                        src_q      <= gnt[1] ? MODE_DEC : MODE_ENC;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        state_q    <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    // A done on the final timeout cycle still counts as a good result.
                    if (core_done) begin
                        rsp_data  <= core_dout;
                        rsp_err   <= 1'b0;
                        rsp_src   <= src_q;
                        rsp_valid <= 1'b1;
                        state_q   <= ARB_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_src   <= src_q;
                        rsp_valid <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        state_q   <= ARB_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ARB_RESP: begin
                    if (rsp_ready) begin
                        rr_ptr_q  <= ~src_q;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_q   <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Scoreboard bench for aes_core_arbiter with a behavioural AES core model.
module tb_aes_core_arbiter;

    typedef struct packed {
        logic         src;
        logic         err;
        logic [127:0] data;
    } rsp_t;

    localparam logic [127:0] KEY = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_data0, req_data1;
    logic         core_start, core_mode, core_done;
    logic [127:0] core_din, core_dout;
    logic         rsp_valid, rsp_ready, rsp_src, rsp_err, busy;
    logic [127:0] rsp_data;
    logic [7:0]   err_count;
    logic         model_done, spur_done;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   core_lat = 0;
    int   n_starts = 0;
    bit   start_q[$];
    bit   grant_q[$];
    rsp_t exp_q[$];

    assign core_done = model_done | spur_done;

    aes_core_arbiter #(
        .DATA_W         (128),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .core_start (core_start),
        .core_mode  (core_mode),
        .core_din   (core_din),
        .core_done  (core_done),
        .core_dout  (core_dout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_src    (rsp_src),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .err_count  (err_count)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic m);
        return {d[119:0], d[127:120]} ^ (m ? ~KEY : KEY);
    endfunction

    // Core model: done pulse core_lat cycles after the start cycle; core_lat == 0 never answers.
    initial begin
        int          lat;
        logic        m;
        logic [127:0] d;
        model_done = 1'b0;
        core_dout  = '0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                n_starts++;
                start_q.push_back(core_mode);
                if (core_lat > 0) begin
                    lat = core_lat;
                    m   = core_mode;
                    d   = core_din;
                    repeat (lat) @(posedge clk);
                    #1;
                    model_done = 1'b1;
                    core_dout  = core_fn(d, m);
                    @(posedge clk);
                    #1;
                    model_done = 1'b0;
                    core_dout  = '0;
                end
            end
        end
    end

    // Grant recorder and one-hot ready check.
    initial forever begin
        @(negedge clk);
        if (reset_n === 1'b1) begin
            n_checks++;
            if (req_ready === 2'b11) begin
                n_errors++;
                $display("FAIL ready_onehot: got %b, want at most one bit", req_ready);
            end
            if (|(req_valid & req_ready)) grant_q.push_back(req_ready[1]);
        end
    end

    // Response scoreboard.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rsp_unexpected: got src=%b err=%b data=%h, want none",
                             rsp_src, rsp_err, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_src, rsp_err, rsp_data} !== e) begin
                        n_errors++;
                        $display("FAIL rsp_payload: got src=%b err=%b data=%h, want src=%b err=%b data=%h",
                                 rsp_src, rsp_err, rsp_data, e.src, e.err, e.data);
                    end
                end
            end
        end
    end

    task automatic wait_grant(input int budget, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic wait_rsp_valid(input int budget, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && rsp_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b00 || core_start !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got ready=%b start=%b busy=%b, want 00 0 0",
                     req_ready, core_start, busy);
        end
        n_checks++;
        if (core_mode !== 1'b0 || core_din !== '0) begin
            n_errors++;
            $display("FAIL reset_core: got mode=%b din=%h, want 0 and zero", core_mode, core_din);
        end
        n_checks++;
        if ({rsp_valid, rsp_src, rsp_err, rsp_data} !== '0 || err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_rsp: got valid=%b src=%b err=%b data=%h cnt=%0d, want all zero",
                     rsp_valid, rsp_src, rsp_err, rsp_data, err_count);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single_encrypt();
        int t0, t;
        bit ok;
        logic [127:0] d;
        d        = 128'h00112233445566778899aabbccddeeff;
        core_lat = 31;
        n_starts = 0;
        exp_q.push_back(rsp_t'({1'b0, 1'b0, core_fn(d, 1'b0)}));
        @(posedge clk);
        #1;
        req_data0 = d;
        req_valid = 2'b01;
        wait_grant(20, t0, ok);
        n_checks++;
        if (!ok || req_ready !== 2'b01) begin
            n_errors++;
            $display("FAIL single_grant: got ok=%b ready=%b, want 1 01", ok, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({core_start, core_mode, core_din} !== {1'b1, 1'b0, d}) begin
            n_errors++;
            $display("FAIL single_issue: got start=%b mode=%b din=%h, want 1 0 %h",
                     core_start, core_mode, core_din, d);
        end
        @(negedge clk);
        n_checks++;
        if (core_start !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_pulse: got start=%b busy=%b, want 0 1", core_start, busy);
        end
        wait_rsp_valid(60, t, ok);
        n_checks++;
        if (!ok || t != t0 + 33) begin
            n_errors++;
            $display("FAIL single_latency: got ok=%b cycle=%0d, want cycle %0d", ok, t, t0 + 33);
        end
        wait_idle(20, ok);
        n_checks++;
        if (!ok || n_starts != 1) begin
            n_errors++;
            $display("FAIL single_done: got idle=%b starts=%0d, want 1 1", ok, n_starts);
        end
    endtask

    task automatic test_contention();
        bit ok;
        logic [127:0] a, b;
        a = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        b = 128'h13579bdf_2468ace0_fedcba98_76543210;
        apply_reset();
        core_lat = 5;
        start_q.delete();
        grant_q.delete();
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_q.push_back(rsp_t'({1'b0, 1'b0, core_fn(a, 1'b0)}));
            else            exp_q.push_back(rsp_t'({1'b1, 1'b0, core_fn(b, 1'b1)}));
        end
        @(posedge clk);
        #1;
        req_data0 = a;
        req_data1 = b;
        req_valid = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (grant_q.size() >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL contention_grants: got %0d grants, want 4", grant_q.size());
        end
        wait_idle(40, ok);
        n_checks++;
        if (grant_q.size() != 4 || start_q.size() != 4) begin
            n_errors++;
            $display("FAIL contention_count: got grants=%0d starts=%0d, want 4 4",
                     grant_q.size(), start_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (grant_q[i] !== bit'(i % 2) || start_q[i] !== bit'(i % 2)) begin
                    n_errors++;
                    $display("FAIL contention_order: job %0d got grant=%0d mode=%0d, want %0d",
                             i, grant_q[i], start_q[i], i % 2);
                end
            end
        end
        n_checks++;
        if (err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL contention_errcnt: got %0d, want 0", err_count);
        end
    endtask

    task automatic test_timeout();
        int t0, t;
        bit ok;
        logic [127:0] c, d;
        c = 128'h0badc0de_0badc0de_0badc0de_0badc0de;
        d = 128'h11111111_22222222_33333333_44444444;
        core_lat = 0;
        exp_q.push_back(rsp_t'({1'b0, 1'b1, 128'h0}));
        @(posedge clk);
        #1;
        req_data0 = c;
        req_valid = 2'b01;
        wait_grant(20, t0, ok);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_rsp_valid(100, t, ok);
        n_checks++;
        if (!ok || t != t0 + 66) begin
            n_errors++;
            $display("FAIL timeout_latency: got ok=%b cycle=%0d, want cycle %0d", ok, t, t0 + 66);
        end
        n_checks++;
        if (err_count !== 8'd1) begin
            n_errors++;
            $display("FAIL timeout_errcnt: got %0d, want 1", err_count);
        end
        wait_idle(20, ok);
        core_lat = 3;
        exp_q.push_back(rsp_t'({1'b1, 1'b0, core_fn(d, 1'b1)}));
        @(posedge clk);
        #1;
        req_data1 = d;
        req_valid = 2'b10;
        wait_grant(20, t0, ok);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_rsp_valid(30, t, ok);
        n_checks++;
        if (!ok || t != t0 + 5 || err_count !== 8'd1) begin
            n_errors++;
            $display("FAIL timeout_recover: got ok=%b cycle=%0d cnt=%0d, want cycle %0d cnt 1",
                     ok, t, err_count, t0 + 5);
        end
        wait_idle(20, ok);
    endtask

    task automatic test_backpressure();
        int t0, t;
        bit ok;
        logic [127:0] e, x;
        e = 128'hfeedface_00000000_ffffffff_a5a5a5a5;
        x = core_fn(e, 1'b0);
        core_lat  = 4;
        rsp_ready = 1'b0;
        exp_q.push_back(rsp_t'({1'b0, 1'b0, x}));
        @(posedge clk);
        #1;
        req_data0 = e;
        req_valid = 2'b01;
        wait_grant(20, t0, ok);
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        wait_rsp_valid(30, t, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL bp_valid: got no rsp_valid, want rsp_valid");
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({rsp_valid, rsp_src, rsp_err, req_ready, busy, rsp_data}
                    !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b1, x}) begin
                n_errors++;
                $display("FAIL bp_hold: cycle %0d got v=%b s=%b e=%b rdy=%b busy=%b d=%h, want 1 0 0 00 1 %h",
                         i, rsp_valid, rsp_src, rsp_err, req_ready, busy, rsp_data, x);
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_release: got busy=%b valid=%b, want 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_spurious_done();
        int t0, t;
        bit ok;
        logic [127:0] f;
        f = 128'h0123_4567_89ab_cdef_0f0f_f0f0_1234_abcd;
        core_lat = 6;
        @(posedge clk);
        #1;
        spur_done = 1'b1;
        @(posedge clk);
        #1;
        spur_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL spur_idle: got valid=%b busy=%b, want 0 0", rsp_valid, busy);
            end
        end
        exp_q.push_back(rsp_t'({1'b0, 1'b0, core_fn(f, 1'b0)}));
        @(posedge clk);
        #1;
        req_data0 = f;
        req_valid = 2'b01;
        wait_grant(20, t0, ok);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        spur_done = 1'b1;
        @(negedge clk);
        n_checks++;
        if (core_start !== 1'b1) begin
            n_errors++;
            $display("FAIL spur_issue: got start=%b, want 1", core_start);
        end
        @(posedge clk);
        #1;
        spur_done = 1'b0;
        wait_rsp_valid(30, t, ok);
        n_checks++;
        if (!ok || t != t0 + 8) begin
            n_errors++;
            $display("FAIL spur_latency: got ok=%b cycle=%0d, want cycle %0d", ok, t, t0 + 8);
        end
        wait_idle(20, ok);
    endtask

    task automatic test_reset_mid_wait();
        int t0;
        bit ok;
        logic [127:0] g, h, k;
        g = 128'haaaa5555_aaaa5555_aaaa5555_aaaa5555;
        h = 128'h0000ffff_0000ffff_1234_5678_9abc_def0;
        k = 128'h76543210_fedcba98_01010101_80808080;
        core_lat = 0;
        @(posedge clk);
        #1;
        req_data0 = g;
        req_valid = 2'b01;
        wait_grant(20, t0, ok);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        repeat (11) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, core_start, core_mode, core_din, rsp_valid, rsp_data, rsp_src, rsp_err,
             busy, err_count} !== '0) begin
            n_errors++;
            $display("FAIL midreset_async: got busy=%b din=%h cnt=%0d valid=%b, want all zero",
                     busy, core_din, err_count, rsp_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        core_lat = 3;
        grant_q.delete();
        exp_q.push_back(rsp_t'({1'b0, 1'b0, core_fn(h, 1'b0)}));
        exp_q.push_back(rsp_t'({1'b1, 1'b0, core_fn(k, 1'b1)}));
        req_data0 = h;
        req_data1 = k;
        req_valid = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (grant_q.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        n_checks++;
        if (!ok || grant_q[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_first_grant: got ok=%b grants=%0d, want requester 0 first",
                     ok, grant_q.size());
        end
        wait_idle(40, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL midreset_idle: got busy=%b, want 0", busy);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        rsp_ready = 1'b1;
        spur_done = 1'b0;
        test_reset();
        test_single_encrypt();
        test_contention();
        test_timeout();
        test_backpressure();
        test_spurious_done();
        test_reset_mid_wait();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rsp_missing: got %0d outstanding, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
